param_lifo_stack: RTL and testbench
===================================

// Module: param_lifo_stack
// PURPOSE
//  Parametrised LIFO stack: generic data width and depth, full/empty/count status,
//  a registered top-of-stack output and a one-cycle done pulse per accepted operation.
//  Simultaneous push+pop performs an atomic replace-top.
//  Overflow/underflow attempts latch a sticky error state that only a synchronous clear exits.
//  Sits between the tile I/O pins and core logic as the team's general stack primitive.
// PARAMETERS
//  WIDTH  8   data word width in bits (>=1)
//  DEPTH  16  number of entries (>=2, any integer, not restricted to powers of two)
//  CW     $clog2(DEPTH+1)  derived count width; localparam, not overridable
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  clear    in   1      synchronous clear: empties the stack and leaves ERR; wins over push/pop
//  push     in   1      push request, sampled at rising clk
//  pop      in   1      pop request, sampled at rising clk
//  din      in   WIDTH  data to push, sampled with push
//  dout     out  WIDTH  registered top-of-stack; 0 when empty
//  count    out  CW     number of valid entries, 0..DEPTH
//  empty    out  1      count==0
//  full     out  1      count==DEPTH
//  done     out  1      1-cycle pulse: the previous cycle's operation was accepted
//  ovf_err  out  1      sticky: a push was attempted while full (push alone, not with pop)
//  unf_err  out  1      sticky: a pop was attempted while empty (pop alone, not with push)
// BEHAVIOUR
//  Reset (rst_n low, async): dout=0, count=0, empty=1, full=0, done=0, ovf_err=0, unf_err=0.
//   State=OK. Memory contents are don't-care and are never visible on dout.
//  FSM has two states: OK and ERR.
//   OK->ERR when push&!pop&full, or when pop&!push&empty. The offending op is ignored.
//   ERR->OK only on clear. In ERR, push/pop are ignored, done stays 0, errors are held.
//  Ops in state OK, with sp = count:
//   push only, !full: mem[sp]<=din, count+1, dout<=din, done<=1.
//   pop only, !empty: count-1, dout<=mem[sp-2] if sp>=2 else 0, done<=1.
//   push+pop, !empty: mem[sp-1]<=din, count unchanged, dout<=din, done<=1 (replace-top).
//   push+pop, empty: treated as push only; no underflow is flagged.
//   push+pop, full: replace-top as above; no overflow is flagged.
//  Latency: for an op sampled at edge N, dout/count/flags/done are valid after edge N.
//   Back-to-back ops on every cycle are supported with no bubbles.
//  clear (any state): count<=0, dout<=0, errors<=0, done<=0, state<=OK.
//   clear has priority over push/pop in the same cycle.
//  empty/full are derived from the registered count; no combinational path from push/pop/din.
//  Count arithmetic uses CW bits; it never wraps because of the full/empty guards.
//  Reset asserted mid-operation: all outputs return to reset values immediately.
// TESTING
//  T1 reset, push 0x11,0x22,0x33 on consecutive cycles -> count=3, dout=0x33, done high 3 cycles.
//  T2 continue from T1, pop x3 -> dout 0x22,0x11,0x00; empty=1 after third pop; count=0.
//  T3 DEPTH=16, push 16 words then one more push -> full=1, ovf_err=1, ERR state;
//   a following pop is ignored (count stays 16); clear -> count=0, ovf_err=0, state OK.
//  T4 on an empty stack, pop -> unf_err=1, done=0, dout=0; same cycle push+pop on empty
//   after clear -> count=1, dout=din, no error.
//  T5 with 0xAA,0xBB stacked, push+pop with din=0xCC -> count=2, dout=0xCC;
//   pop -> dout=0xAA.
//  T6 drop rst_n mid-burst between clk edges -> outputs zero at once; with DEPTH=5, WIDTH=12
//   fill/drain gives full exactly at count=5.

Source files
------------

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with registered top-of-stack, count/full/empty status,
// per-operation done pulse, atomic replace-top on push+pop and sticky over/underflow errors.
module param_lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             done,
  output logic             ovf_err,
  output logic             unf_err,
  output logic             o_dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic {
    ST_OK  = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic [CW-1:0]    r_count;
  logic             r_done;
  logic             r_ovf;
  logic             r_unf;

  logic             w_ok;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_both;
  logic             w_do_push;
  logic             w_do_repl;
  logic             w_do_pop;
  logic             w_ovf;
  logic             w_unf;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_below_idx;
  logic [WIDTH-1:0] w_pop_data;

  assign empty       = (r_count == '0);
  assign full        = (r_count == C_DEPTH);
  assign dout        = r_dout;
  assign count       = r_count;
  assign done        = r_done;
  assign ovf_err     = r_ovf;
  assign unf_err     = r_unf;
  assign o_dbg_state = (r_state == ST_ERR);

  // Push+pop on an empty stack degrades to a plain push; on a full stack it is a replace.
  assign w_ok        = (r_state == ST_OK) && !clear;
  assign w_push_only = w_ok && push && !pop;
  assign w_pop_only  = w_ok && pop && !push;
  assign w_both      = w_ok && push && pop;
  assign w_do_push   = (w_push_only && !full) || (w_both && empty);
  assign w_do_repl   = w_both && !empty;
  assign w_do_pop    = w_pop_only && !empty;
  assign w_ovf       = w_push_only && full;
  assign w_unf       = w_pop_only && empty;

  assign w_wr_idx    = w_do_repl ? AW'(r_count - CW'(1)) : AW'(r_count);
  assign w_below_idx = AW'(r_count - CW'(2));
  assign w_pop_data  = (r_count >= CW'(2)) ? r_mem[w_below_idx] : '0;

  always_ff @(posedge clk) begin
    if (w_do_push || w_do_repl) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OK;
      r_dout  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clear) begin
      r_state <= ST_OK;
      r_dout  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      case (r_state)
        ST_OK: begin
          r_done <= w_do_push || w_do_repl || w_do_pop;
          if (w_do_push) begin
            r_count <= r_count + CW'(1);
            r_dout  <= din;
          end else if (w_do_repl) begin
            r_dout  <= din;
          end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
            r_dout  <= w_pop_data;
          end else if (w_ovf) begin
            r_ovf   <= 1'b1;
            r_state <= ST_ERR;
          end else if (w_unf) begin
            r_unf   <= 1'b1;
            r_state <= ST_ERR;
          end
        end
        ST_ERR: begin
          r_done <= 1'b0;
        end
        default: begin
          r_state <= ST_OK;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_lifo_stack.sv
// Bench for param_lifo_stack: two instances (16x8 and 5x12) driven in lockstep and
// compared every cycle against a queue of expectations from a stack-level model.
module tb_param_lifo_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [11:0] din = '0;

  logic [7:0]  dout0;
  logic [4:0]  count0;
  logic        empty0, full0, done0, ovf0, unf0, dbg0;
  logic [11:0] dout1;
  logic [2:0]  count1;
  logic        empty1, full1, done1, ovf1, unf1, dbg1;

  int checks = 0;
  int errors = 0;

  // Expected vector: {err, ovf, unf, done, full, empty, count[4:0], dout[11:0]}
  logic [22:0] exp_q0[$];
  logic [22:0] exp_q1[$];

  int          m_n   [2];
  logic [11:0] m_stk [2][16];
  bit          m_err [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  bit          m_done[2];

  always #5 clk = ~clk;

  param_lifo_stack #(.WIDTH(8), .DEPTH(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .pop(pop), .din(din[7:0]),
    .dout(dout0), .count(count0), .empty(empty0), .full(full0), .done(done0),
    .ovf_err(ovf0), .unf_err(unf0), .o_dbg_state(dbg0)
  );

  param_lifo_stack #(.WIDTH(12), .DEPTH(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .pop(pop), .din(din),
    .dout(dout1), .count(count1), .empty(empty1), .full(full1), .done(done1),
    .ovf_err(ovf1), .unf_err(unf1), .o_dbg_state(dbg1)
  );

  function automatic int depth_of(input int k);
    return (k == 0) ? 16 : 5;
  endfunction

  function automatic logic [11:0] mask_of(input int k);
    return (k == 0) ? 12'h0FF : 12'hFFF;
  endfunction

  function automatic logic [22:0] exp_vec(input int k);
    logic [11:0] top;
    top = (m_n[k] > 0) ? m_stk[k][m_n[k]-1] : 12'h000;
    return {m_err[k], m_ovf[k], m_unf[k], m_done[k], (m_n[k] == depth_of(k)),
            (m_n[k] == 0), 5'(m_n[k]), top};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_err[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit p, input bit q, input bit c,
                            input logic [11:0] d);
    logic [11:0] dm;
    dm = d & mask_of(k);
    m_done[k] = 0;
    if (c) begin
      m_n[k] = 0; m_err[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end else if (m_err[k]) begin
      m_done[k] = 0;
    end else if (p && q && m_n[k] > 0) begin
      m_stk[k][m_n[k]-1] = dm;
      m_done[k] = 1;
    end else if (p && m_n[k] < depth_of(k)) begin
      m_stk[k][m_n[k]] = dm;
      m_n[k]++;
      m_done[k] = 1;
    end else if (p && !q) begin
      m_err[k] = 1; m_ovf[k] = 1;
    end else if (q && !p && m_n[k] > 0) begin
      m_n[k]--;
      m_done[k] = 1;
    end else if (q && !p) begin
      m_err[k] = 1; m_unf[k] = 1;
    end
  endtask

  task automatic cmp(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what both stacks must show after the edge.
  task automatic step(input bit p, input bit q, input bit c, input logic [11:0] d);
    @(negedge clk);
    push = p; pop = q; clear = c; din = d;
    model_step(0, p, q, c, d);
    model_step(1, p, q, c, d);
    exp_q0.push_back(exp_vec(0));
    exp_q1.push_back(exp_vec(1));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout0", 32'(dout0), 32'h0);
    chk("arst_count0", 32'(count0), 32'h0);
    chk("arst_empty0", 32'(empty0), 32'h1);
    chk("arst_done0", 32'(done0), 32'h0);
    chk("arst_dout1", 32'(dout1), 32'h0);
    chk("arst_count1", 32'(count1), 32'h0);
    model_reset();
    exp_q0.push_back(exp_vec(0));
    exp_q1.push_back(exp_vec(1));
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    rst_n = 1'b1;
    exp_q0.push_back(exp_vec(0));
    exp_q1.push_back(exp_vec(1));
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) begin
      cmp("sb_dut0", {dbg0, ovf0, unf0, done0, full0, empty0, count0, 4'b0, dout0},
          exp_q0.pop_front());
    end
    if (exp_q1.size() > 0) begin
      cmp("sb_dut1", {dbg1, ovf1, unf1, done1, full1, empty1, 2'b0, count1, dout1},
          exp_q1.pop_front());
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_dout0", 32'(dout0), 32'h0);
    chk("rst_count0", 32'(count0), 32'h0);
    chk("rst_empty0", 32'(empty0), 32'h1);
    chk("rst_full0", 32'(full0), 32'h0);
    chk("rst_err0", 32'({ovf0, unf0, done0}), 32'h0);
    rst_n = 1'b1;

    // push three, then pop three
    step(1, 0, 0, 12'h011);
    step(1, 0, 0, 12'h022);
    step(1, 0, 0, 12'h033);
    after_edge();
    chk("t1_count", 32'(count0), 32'd3);
    chk("t1_dout", 32'(dout0), 32'h33);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 12'h000);
    after_edge();
    chk("t2_empty", 32'(empty0), 32'h1);
    chk("t2_dout", 32'(dout0), 32'h0);

    // fill to 16, overflow, ignored pop, clear
    for (int i = 0; i < 16; i++) step(1, 0, 0, 12'($urandom_range(0, 4095)));
    step(1, 0, 0, 12'h0EE);
    step(0, 1, 0, 12'h000);
    after_edge();
    chk("t3_count", 32'(count0), 32'd16);
    chk("t3_ovf", 32'(ovf0), 32'h1);
    chk("t3_full", 32'(full0), 32'h1);
    step(0, 0, 1, 12'h000);
    after_edge();
    chk("t3_clr_count", 32'(count0), 32'd0);
    chk("t3_clr_ovf", 32'(ovf0), 32'h0);

    // underflow, then push+pop on empty
    step(0, 1, 0, 12'h000);
    after_edge();
    chk("t4_unf", 32'(unf0), 32'h1);
    chk("t4_done", 32'(done0), 32'h0);
    step(0, 0, 1, 12'h000);
    step(1, 1, 0, 12'h05A);
    after_edge();
    chk("t4_count", 32'(count0), 32'd1);
    chk("t4_dout", 32'(dout0), 32'h5A);
    chk("t4_noerr", 32'({ovf0, unf0}), 32'h0);

    // replace-top
    step(0, 0, 1, 12'h000);
    step(1, 0, 0, 12'h0AA);
    step(1, 0, 0, 12'h0BB);
    step(1, 1, 0, 12'h0CC);
    after_edge();
    chk("t5_dout", 32'(dout0), 32'hCC);
    chk("t5_count", 32'(count0), 32'd2);
    step(0, 1, 0, 12'h000);
    after_edge();
    chk("t5_pop", 32'(dout0), 32'hAA);

    // async reset mid-burst
    step(1, 0, 0, 12'h123);
    step(1, 0, 0, 12'h456);
    async_reset();

    // small instance fill/drain and full-replace
    for (int i = 0; i < 5; i++) step(1, 0, 0, 12'(12'h900 + i));
    after_edge();
    chk("t6_full1", 32'(full1), 32'h1);
    chk("t6_count1", 32'(count1), 32'd5);
    step(1, 1, 0, 12'hABC);
    step(1, 0, 0, 12'hDEF);
    after_edge();
    chk("t6_ovf1", 32'(ovf1), 32'h1);
    step(0, 0, 1, 12'h000);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 12'($urandom_range(0, 4095)));
    for (int i = 0; i < 6; i++) step(0, 1, 0, 12'h000);
    step(0, 0, 1, 12'h000);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 29) == 0), 12'($urandom_range(0, 4095)));
    end
    step(0, 0, 0, 12'h000);
    repeat (2) after_edge();
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
